cache_writeback_buffer: RTL and testbench

//   Write direction of the cache/main-memory path: queues dirty 512-bit lines evicted by cache_mem,

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_writeback_buffer_if.sv | 27 ++
 rtl/cache_writeback_buffer_wb_fifo.sv | 72 +++++++
 rtl/cache_writeback_buffer.sv | 139 +++++++++++++
 tb/tb_cache_writeback_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache-path definitions: line/beat geometry and writeback drain states.
// Used by cache_mem, cache_controller and cache_writeback_buffer.
package cache_pkg;

    localparam int LINE_W      = 512;
    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / WORD_W;
    localparam int BEAT_W      = $clog2(BEATS);
    localparam int OFFSET_BITS = 6;
    localparam int TAG_W       = ADDR_W - OFFSET_BITS;

    typedef enum logic {
        WB_IDLE,
        WB_SEND
    } wb_state_t;

    // Byte address of one beat within a line: {line_addr, beat, word offset 00}.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]  line_tag,
                                                    input logic [BEAT_W-1:0] beat);
        return {line_tag, beat, 2'b00};
    endfunction

endpackage

// File: rtl/cache_writeback_buffer_if.sv
// Eviction-side and memory-write-side handshake bundle of the writeback buffer.
// slave: the buffer's view; master: the surrounding cache_mem/main_mem view.
interface cache_writeback_buffer_if;
    import cache_pkg::*;

    logic              evict_valid;
    logic              evict_ready;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;

    logic              mem_wvalid;
    logic              mem_wready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_wlast;

    modport slave (
        input  evict_valid, evict_addr, evict_data, mem_wready,
        output evict_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );

    modport master (
        output evict_valid, evict_addr, evict_data, mem_wready,
        input  evict_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );

endinterface

// File: rtl/cache_writeback_buffer_wb_fifo.sv
// Line storage for the writeback buffer: DEPTH entries of {line_addr[31:6], line data},
// head/tail pointers, occupancy count and a per-entry valid vector for address lookup.
module wb_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic [LINE_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [PTR_W-1:0]  head_o,
    output logic [TAG_W-1:0]  tag_o   [DEPTH],
    output logic [LINE_W-1:0] data_o  [DEPTH],
    output logic [DEPTH-1:0]  valid_o
);

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointers, count and valid bits; reset discards every buffered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_i) begin
                tail_q          <= next_ptr(tail_q);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop_i) begin
                head_q          <= next_ptr(head_q);
                valid_q[head_q] <= 1'b0;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            tag_q[tail_q]  <= push_tag_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/cache_writeback_buffer.sv
// Writeback buffer: queues evicted dirty lines and drains each one to main memory as
// BEATS sequential WORD_W beats. Optional read-miss forwarding lookup is enabled by
// defining CACHE_WB_FWD_EN; without it lookup_hit/lookup_data are tied to zero.
module cache_writeback_buffer
    import cache_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_writeback_buffer_if.slave bus,
    output logic                    wb_empty,
    output logic [CNT_W-1:0]        wb_count,
    input  logic [ADDR_W-1:0]       lookup_addr,
    output logic                    lookup_hit,
    output logic [LINE_W-1:0]       lookup_data
);

    wb_state_t         state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              wvalid_q;
    logic              wlast_q;

    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [TAG_W-1:0]  ent_tag   [DEPTH];
    logic [LINE_W-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [LINE_W-1:0] head_data;
    logic              push;
    logic              pop;

    // Ready comes from the registered count only: a pop in the same cycle does not free a slot.
    assign bus.evict_ready = (count < CNT_W'(DEPTH));
    assign push            = bus.evict_valid & bus.evict_ready;
    assign pop             = (state_q == WB_SEND) & bus.mem_wready & (beat_q == BEAT_W'(BEATS - 1));

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_tag_i  (bus.evict_addr[ADDR_W-1:OFFSET_BITS]),
        .push_data_i (bus.evict_data),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head),
        .tag_o       (ent_tag),
        .data_o      (ent_data),
        .valid_o     (ent_valid)
    );

    // Drain FSM: one line at a time, beats 0..BEATS-1, back-to-back when more lines wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WB_IDLE;
            beat_q   <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    beat_q  <= '0;
                    wlast_q <= 1'b0;
                    if (count != '0) begin
                        state_q  <= WB_SEND;
                        wvalid_q <= 1'b1;
                    end else begin
                        wvalid_q <= 1'b0;
                    end
                end
                WB_SEND: begin
                    if (bus.mem_wready) begin
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            beat_q  <= '0;
                            wlast_q <= 1'b0;
                            if (count > CNT_W'(1)) begin
                                state_q  <= WB_SEND;
                                wvalid_q <= 1'b1;
                            end else begin
                                state_q  <= WB_IDLE;
                                wvalid_q <= 1'b0;
                            end
                        end else begin
                            beat_q  <= beat_q + BEAT_W'(1);
                            wlast_q <= (beat_q == BEAT_W'(BEATS - 2));
                        end
                    end
                end
                default: begin
                    state_q  <= WB_IDLE;
                    wvalid_q <= 1'b0;
                    wlast_q  <= 1'b0;
                    beat_q   <= '0;
                end
            endcase
        end
    end

    assign head_data      = ent_data[head];
    assign bus.mem_wvalid = wvalid_q;
    assign bus.mem_wlast  = wlast_q;
    assign bus.mem_waddr  = beat_addr(ent_tag[head], beat_q);
    assign bus.mem_wdata  = head_data[{beat_q, 5'b00000} +: WORD_W];

    assign wb_count = count;
    assign wb_empty = (count == '0) && (state_q == WB_IDLE);

`ifdef CACHE_WB_FWD_EN
    // Probe every valid entry oldest-to-youngest so the youngest match overrides older ones.
    always_comb begin
        int idx;
        idx         = 0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(head) + i;
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            if (ent_valid[idx] && (ent_tag[idx] == lookup_addr[ADDR_W-1:OFFSET_BITS])) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[idx];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd  = ^{lookup_addr, ent_valid};
    assign lookup_hit  = 1'b0;
    assign lookup_data = '0;
`endif

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed testbench for cache_writeback_buffer: single-line drain, full buffer,
// stalled handshake, push/pop collision, mid-burst reset and (with CACHE_WB_FWD_EN) lookup.
module tb_cache_writeback_buffer;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_empty;
    logic [2:0]        wb_count;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [65:0]  got_beat, exp_beat;
    logic [LINE_W:0] got_fwd, exp_fwd;

    cache_writeback_buffer_if bus ();

    cache_writeback_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .wb_empty    (wb_empty),
        .wb_count    (wb_count),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    function automatic logic [65:0] beat_vec(input logic [31:0] line_addr, input logic [31:0] base,
                                             input int b);
        return {1'b1, line_addr + 32'(4 * b), base + 32'(b), (b == 15)};
    endfunction

    task automatic drive_evict(input logic v, input logic [31:0] a, input logic [31:0] base);
        bus.evict_valid = v;
        bus.evict_addr  = a;
        bus.evict_data  = mk_line(base);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count, lookup_hit} !== 8'b0011_0000)
            $display("FAIL reset_in got %b want 00110000",
                     {bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count, lookup_hit});
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count, lookup_hit} !== 8'b0011_0000)
            $display("FAIL reset_out got %b want 00110000",
                     {bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count, lookup_hit});
        else pass_cnt++;
    endtask

    task automatic test_single_line;
        bus.mem_wready = 1'b1;
        drive_evict(1'b1, 32'h0000_1040, 32'hA000_0000);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        total_cnt++;
        if ({bus.mem_wvalid, wb_count} !== 4'b0_001)
            $display("FAIL single_c1 got wvalid,count=%b want 0001", {bus.mem_wvalid, wb_count});
        else pass_cnt++;
        @(negedge clk);
        for (int b = 0; b < 16; b++) begin
            got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
            exp_beat = beat_vec(32'h0000_1040, 32'hA000_0000, b);
            total_cnt++;
            if (got_beat !== exp_beat) $display("FAIL single_beat%0d got %h want %h", b, got_beat, exp_beat);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({bus.mem_wvalid, wb_empty, wb_count} !== 5'b0_1_000)
            $display("FAIL single_done got %b want 01000", {bus.mem_wvalid, wb_empty, wb_count});
        else pass_cnt++;
        bus.mem_wready = 1'b0;
    endtask

    task automatic test_full;
        bus.mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_evict(1'b1, 32'h0000_4000 + 32'(i * 64), 32'hB000_0000 + 32'(i * 256));
            @(negedge clk);
        end
        total_cnt++;
        if ({bus.evict_ready, wb_count} !== 4'b0_100)
            $display("FAIL full_after4 got ready,count=%b want 0100", {bus.evict_ready, wb_count});
        else pass_cnt++;
        drive_evict(1'b1, 32'h0000_4100, 32'hB000_0400);
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.evict_ready, wb_count} !== 4'b0_100)
            $display("FAIL full_held got ready,count=%b want 0100", {bus.evict_ready, wb_count});
        else pass_cnt++;
        got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
        exp_beat = beat_vec(32'h0000_4000, 32'hB000_0000, 0);
        total_cnt++;
        if (got_beat !== exp_beat) $display("FAIL full_stall got %h want %h", got_beat, exp_beat);
        else pass_cnt++;
        bus.mem_wready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
            exp_beat = beat_vec(32'h0000_4000, 32'hB000_0000, b);
            total_cnt++;
            if (got_beat !== exp_beat) $display("FAIL full_l0_beat%0d got %h want %h", b, got_beat, exp_beat);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({bus.evict_ready, wb_count} !== 4'b1_011)
            $display("FAIL full_popped got ready,count=%b want 1011", {bus.evict_ready, wb_count});
        else pass_cnt++;
        for (int j = 1; j < 5; j++) begin
            for (int b = 0; b < 16; b++) begin
                got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
                exp_beat = beat_vec(32'h0000_4000 + 32'(j * 64), 32'hB000_0000 + 32'(j * 256), b);
                total_cnt++;
                if (got_beat !== exp_beat) $display("FAIL full_l%0d_beat%0d got %h want %h", j, b, got_beat, exp_beat);
                else pass_cnt++;
                @(negedge clk);
                if (j == 1 && b == 0) begin
                    bus.evict_valid = 1'b0;
                    total_cnt++;
                    if (wb_count !== 3'd4) $display("FAIL full_5th_accepted got count=%0d want 4", wb_count);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if ({bus.mem_wvalid, wb_empty} !== 2'b01)
            $display("FAIL full_done got wvalid,empty=%b want 01", {bus.mem_wvalid, wb_empty});
        else pass_cnt++;
        bus.mem_wready = 1'b0;
    endtask

    task automatic test_toggle;
        int line;
        int beat;
        logic [31:0] la;
        bus.mem_wready = 1'b0;
        drive_evict(1'b1, 32'h0000_5000, 32'hC000_0000);
        @(negedge clk);
        drive_evict(1'b1, 32'h0000_5040, 32'hC000_0100);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        line = 0;
        beat = 0;
        for (int cyc = 0; cyc < 63; cyc++) begin
            bus.mem_wready = (cyc % 2 == 0);
            la = 32'h0000_5000 + 32'(line * 64);
            got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
            exp_beat = beat_vec(la, 32'hC000_0000 + 32'(line * 256), beat);
            total_cnt++;
            if (got_beat !== exp_beat) $display("FAIL toggle_cyc%0d got %h want %h", cyc, got_beat, exp_beat);
            else pass_cnt++;
            @(negedge clk);
            if (cyc % 2 == 0) begin
                if (beat == 15) begin
                    beat = 0;
                    line++;
                end else begin
                    beat++;
                end
            end
        end
        total_cnt++;
        if ({bus.mem_wvalid, wb_empty} !== 2'b01)
            $display("FAIL toggle_done got wvalid,empty=%b want 01", {bus.mem_wvalid, wb_empty});
        else pass_cnt++;
        bus.mem_wready = 1'b0;
    endtask

    task automatic test_push_pop;
        bus.mem_wready = 1'b0;
        drive_evict(1'b1, 32'h0000_6000, 32'hD000_0000);
        @(negedge clk);
        drive_evict(1'b1, 32'h0000_6040, 32'hD000_0100);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        bus.mem_wready  = 1'b1;
        for (int b = 0; b < 16; b++) begin
            got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
            exp_beat = beat_vec(32'h0000_6000, 32'hD000_0000, b);
            total_cnt++;
            if (got_beat !== exp_beat) $display("FAIL pp_l0_beat%0d got %h want %h", b, got_beat, exp_beat);
            else pass_cnt++;
            if (b == 15) drive_evict(1'b1, 32'h0000_6080, 32'hD000_0200);
            @(negedge clk);
        end
        bus.evict_valid = 1'b0;
        total_cnt++;
        if (wb_count !== 3'd2) $display("FAIL pp_count got %0d want 2", wb_count);
        else pass_cnt++;
        for (int j = 1; j < 3; j++) begin
            for (int b = 0; b < 16; b++) begin
                got_beat = {bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast};
                exp_beat = beat_vec(32'h0000_6000 + 32'(j * 64), 32'hD000_0000 + 32'(j * 256), b);
                total_cnt++;
                if (got_beat !== exp_beat) $display("FAIL pp_l%0d_beat%0d got %h want %h", j, b, got_beat, exp_beat);
                else pass_cnt++;
                @(negedge clk);
            end
        end
        total_cnt++;
        if ({bus.mem_wvalid, wb_empty} !== 2'b01)
            $display("FAIL pp_done got wvalid,empty=%b want 01", {bus.mem_wvalid, wb_empty});
        else pass_cnt++;
        bus.mem_wready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_evict(1'b1, 32'h0000_7000 + 32'(i * 64), 32'h7000_0000 + 32'(i * 256));
            @(negedge clk);
        end
        bus.evict_valid = 1'b0;
        bus.mem_wready  = 1'b1;
        repeat (7) @(negedge clk);
        total_cnt++;
        if ({bus.mem_wvalid, bus.mem_waddr, wb_count} !== {1'b1, 32'h0000_701C, 3'd3})
            $display("FAIL rstmid_beat7 got %h want %h", {bus.mem_wvalid, bus.mem_waddr, wb_count},
                     {1'b1, 32'h0000_701C, 3'd3});
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count} !== 7'b0011_000)
            $display("FAIL rstmid_after got %b want 0011000",
                     {bus.mem_wvalid, bus.mem_wlast, bus.evict_ready, wb_empty, wb_count});
        else pass_cnt++;
        rst = 1'b0;
        bus.mem_wready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.mem_wvalid, wb_empty, wb_count} !== 5'b0_1_000)
            $display("FAIL rstmid_discarded got %b want 01000", {bus.mem_wvalid, wb_empty, wb_count});
        else pass_cnt++;
    endtask

    task automatic test_fwd;
        int n;
        bus.mem_wready = 1'b0;
`ifdef CACHE_WB_FWD_EN
        drive_evict(1'b1, 32'h0000_2000, 32'hE000_0000);
        @(negedge clk);
        drive_evict(1'b1, 32'h0000_2000, 32'hF000_0000);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        lookup_addr = 32'h0000_2010;
        #1;
        got_fwd = {lookup_hit, lookup_data};
        exp_fwd = {1'b1, mk_line(32'hF000_0000)};
        total_cnt++;
        if (got_fwd !== exp_fwd) $display("FAIL fwd_hit_new got %h want %h", got_fwd, exp_fwd);
        else pass_cnt++;
        lookup_addr = 32'h0000_3000;
        #1;
        got_fwd = {lookup_hit, lookup_data};
        exp_fwd = '0;
        total_cnt++;
        if (got_fwd !== exp_fwd) $display("FAIL fwd_miss got %h want %h", got_fwd, exp_fwd);
        else pass_cnt++;
        bus.mem_wready = 1'b1;
        repeat (20) @(negedge clk);
        lookup_addr = 32'h0000_2010;
        #1;
        got_fwd = {lookup_hit, lookup_data};
        exp_fwd = {1'b1, mk_line(32'hF000_0000)};
        total_cnt++;
        if (got_fwd !== exp_fwd) $display("FAIL fwd_hit_draining got %h want %h", got_fwd, exp_fwd);
        else pass_cnt++;
`else
        drive_evict(1'b1, 32'h0000_2000, 32'hE000_0000);
        @(negedge clk);
        bus.evict_valid = 1'b0;
        lookup_addr = 32'h0000_2000;
        #1;
        got_fwd = {lookup_hit, lookup_data};
        exp_fwd = '0;
        total_cnt++;
        if (got_fwd !== exp_fwd) $display("FAIL nofwd_tied got %h want %h", got_fwd, exp_fwd);
        else pass_cnt++;
        bus.mem_wready = 1'b1;
`endif
        n = 0;
        while (!wb_empty && n < 80) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (wb_empty !== 1'b1) $display("FAIL fwd_drain got empty=%b want 1 within 80 cycles", wb_empty);
        else pass_cnt++;
        lookup_addr = 32'h0000_2000;
        #1;
        total_cnt++;
        if (lookup_hit !== 1'b0) $display("FAIL fwd_after_drain got hit=%b want 0", lookup_hit);
        else pass_cnt++;
        bus.mem_wready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        lookup_addr     = '0;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.mem_wready  = 1'b0;
        test_reset;
        test_single_line;
        test_full;
        test_toggle;
        test_push_pop;
        test_reset_mid;
        test_fwd;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
